// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX control pipeline: register index type, the
// per-stage control record carried from ID into EX, and its bubble value.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
        logic     load;
        logic     a1;
        logic     b1;
        logic     a2;
        logic     b2;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard check of the ID instruction against the EX stage.
// Build option FWD_EN: when defined, ALU results are forwarded and only a
// load in EX stalls ID; when undefined, every EX hazard stalls ID.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_we_i,
    input  logic              ex_load_i,
    input  logic              ex_br_taken_i,
    output logic              haz1_o,
    output logic              haz2_o,
    output logic              id_stall_o
);

    logic exWrites;
    logic anyHaz;

    // A source hazards only when EX really writes that same non-x0 register;
    // the MEM writer is covered by the write-first regfile.
    always_comb begin
        exWrites = ex_valid_i & ex_we_i;
        haz1_o   = id_valid_i & id_use_rs1_i & exWrites
                   & (ex_rd_i == id_rs1_i) & (id_rs1_i != '0);
        haz2_o   = id_valid_i & id_use_rs2_i & exWrites
                   & (ex_rd_i == id_rs2_i) & (id_rs2_i != '0);
        anyHaz   = haz1_o | haz2_o;
`ifdef FWD_EN
        id_stall_o = anyHaz & ex_load_i & ~ex_br_taken_i;
`else
        id_stall_o = anyHaz & ~ex_br_taken_i;
`endif
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ID/EX control pipeline register with RAW hazard stall, forward-select
// generation, branch flush and a saturating stall counter.
// Build option FWD_EN: enables ALU-result forwarding (A1_sel/B1_sel); when
// undefined those selects are tied low and every EX hazard stalls.
module ex_hazard_ctrl #(
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              id_a2_sel,
    input  logic              id_b2_sel,
    input  logic              ex_br_taken,
    output logic              id_stall,
    output logic              if_flush,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_we,
    output logic              ex_load,
    output logic              A1_sel,
    output logic              B1_sel,
    output logic              A2_sel,
    output logic              B2_sel,
    output logic              mem_valid,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_we,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    ctrl_t             ex_q, ex_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic haz1;
    logic haz2;
    logic stall;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .ex_valid_i    (ex_q.valid),
        .ex_rd_i       (ex_q.rd),
        .ex_we_i       (ex_q.we),
        .ex_load_i     (ex_q.load),
        .ex_br_taken_i (ex_br_taken),
        .haz1_o        (haz1),
        .haz2_o        (haz2),
        .id_stall_o    (stall)
    );

    // Next EX record: a bubble when killed by a branch, held by a stall or
    // when ID is empty; otherwise the decoded ID fields plus forward selects.
    // MEM simply inherits EX, since a taken branch itself still completes.
    always_comb begin
        ex_d        = CTRL_BUBBLE;
        mem_valid_d = ex_q.valid;
        mem_rd_d    = ex_q.rd;
        mem_we_d    = ex_q.we;
        stall_cnt_d = stall_cnt_q;
        if (!(ex_br_taken | stall | ~id_valid)) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = id_rd;
            ex_d.we    = id_we;
            ex_d.load  = id_load;
`ifdef FWD_EN
            ex_d.a1    = haz1;
            ex_d.b1    = haz2;
`else
            ex_d.a1    = 1'b0;
            ex_d.b1    = 1'b0;
`endif
            ex_d.a2    = id_a2_sel;
            ex_d.b2    = id_b2_sel;
        end
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Pipeline registers and stall counter, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= CTRL_BUBBLE;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_stall  = stall;
    assign if_flush  = ex_br_taken;
    assign ex_valid  = ex_q.valid;
    assign ex_rd     = ex_q.rd;
    assign ex_we     = ex_q.we;
    assign ex_load   = ex_q.load;
    assign A1_sel    = ex_q.a1;
    assign B1_sel    = ex_q.b1;
    assign A2_sel    = ex_q.a2;
    assign B2_sel    = ex_q.b2;
    assign mem_valid = mem_valid_q;
    assign mem_rd    = mem_rd_q;
    assign mem_we    = mem_we_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Randomized bench for ex_hazard_ctrl against a slot-level pipeline model,
// with directed load-use, x0, flush-vs-stall and mid-cycle reset cases.
module tb_ex_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_we = 1'b0;
    logic          id_load = 1'b0;
    logic          id_a2_sel = 1'b0;
    logic          id_b2_sel = 1'b0;
    logic          ex_br_taken = 1'b0;
    logic          id_stall, if_flush, ex_valid, ex_we, ex_load;
    logic          A1_sel, B1_sel, A2_sel, B2_sel, mem_valid, mem_we;
    logic [AW-1:0] ex_rd, mem_rd;
    logic [CW-1:0] stall_cnt;

    int errCount = 0;
    int checkCount = 0;

    // Model of what each stage holds, as plain instruction slots
    bit mExValid, mExWe, mExLoad, mExA1, mExB1, mExA2, mExB2;
    int mExRd;
    bit mMemValid, mMemWe;
    int mMemRd;
    int mCnt;

    ex_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
        .id_load(id_load), .id_a2_sel(id_a2_sel), .id_b2_sel(id_b2_sel),
        .ex_br_taken(ex_br_taken), .id_stall(id_stall), .if_flush(if_flush),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
        .A1_sel(A1_sel), .B1_sel(B1_sel), .A2_sel(A2_sel), .B2_sel(B2_sel),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_we(mem_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mExValid = 0; mExRd = 0; mExWe = 0; mExLoad = 0;
        mExA1 = 0; mExB1 = 0; mExA2 = 0; mExB2 = 0;
        mMemValid = 0; mMemRd = 0; mMemWe = 0; mCnt = 0;
    endtask

    task automatic compareState();
        checkOutput("ex_valid", 32'(ex_valid), 32'(mExValid));
        checkOutput("ex_rd", 32'(ex_rd), mExRd);
        checkOutput("ex_we", 32'(ex_we), 32'(mExWe));
        checkOutput("ex_load", 32'(ex_load), 32'(mExLoad));
        checkOutput("A1_sel", 32'(A1_sel), 32'(mExA1));
        checkOutput("B1_sel", 32'(B1_sel), 32'(mExB1));
        checkOutput("A2_sel", 32'(A2_sel), 32'(mExA2));
        checkOutput("B2_sel", 32'(B2_sel), 32'(mExB2));
        checkOutput("mem_valid", 32'(mem_valid), 32'(mMemValid));
        checkOutput("mem_rd", 32'(mem_rd), mMemRd);
        checkOutput("mem_we", 32'(mem_we), 32'(mMemWe));
        checkOutput("stall_cnt", 32'(stall_cnt), mCnt);
    endtask

    // True when the ID source reads what the instruction sitting in EX writes
    function automatic bit readsFromEx(bit v, bit useSrc, int rs);
        return v && useSrc && (rs != 0) && mExValid && mExWe && (mExRd == rs);
    endfunction

    // One cycle, entered and left at a falling edge: check state, drive ID,
    // check the combinational outputs, then advance the model on the clock.
    task automatic applyStimulus(input bit v, input int rs1, input int rs2, input bit u1,
                                 input bit u2, input int rd, input bit we, input bit ld,
                                 input bit a2, input bit b2, input bit br);
        bit h1, h2, expStall;
        compareState();
        id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = AW'(rd);
        id_we = we; id_load = ld; id_a2_sel = a2; id_b2_sel = b2; ex_br_taken = br;
        h1 = readsFromEx(v, u1, rs1);
        h2 = readsFromEx(v, u2, rs2);
        expStall = (h1 || h2) && (FWD ? mExLoad : 1'b1) && !br;
        #1;
        checkOutput("id_stall", 32'(id_stall), 32'(expStall));
        checkOutput("if_flush", 32'(if_flush), 32'(br));
        @(posedge clk);
        mMemValid = mExValid; mMemRd = mExRd; mMemWe = mExWe;
        if (br || expStall || !v) begin
            mExValid = 0; mExRd = 0; mExWe = 0; mExLoad = 0;
            mExA1 = 0; mExB1 = 0; mExA2 = 0; mExB2 = 0;
        end else begin
            mExValid = 1; mExRd = rd; mExWe = we; mExLoad = ld;
            mExA1 = FWD && h1; mExB1 = FWD && h2; mExA2 = a2; mExB2 = b2;
        end
        if (expStall && mCnt < (1 << CW) - 1) mCnt++;
        @(negedge clk);
    endtask

    task automatic randomCycle();
        applyStimulus($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
    endtask

    initial begin
        int cntBefore;
        resetModel();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Load-use on rs2: one stall, bubble in EX, then re-issue
        applyStimulus(1, 1, 2, 1, 1, 7, 1, 1, 0, 0, 0);
        cntBefore = mCnt;
        applyStimulus(1, 3, 7, 1, 1, 9, 1, 0, 0, 1, 0);
        checkOutput("lu_bubble", 32'(ex_valid), 0);
        checkOutput("lu_mem_rd", 32'(mem_rd), 7);
        applyStimulus(1, 3, 7, 1, 1, 9, 1, 0, 0, 1, 0);
        checkOutput("lu_reissue_valid", 32'(ex_valid), 1);
        checkOutput("lu_reissue_b1", 32'(B1_sel), 0);
        checkOutput("lu_cnt", 32'(stall_cnt), cntBefore + 1);

        // x0 destination never creates a hazard
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 4, 1, 0, 5, 1, 0, 1, 0, 0);
        checkOutput("x0_valid", 32'(ex_valid), 1);
        checkOutput("x0_a1", 32'(A1_sel), 0);

        // ALU RAW: forwarded with FWD_EN, otherwise a one-cycle stall
        applyStimulus(1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        applyStimulus(1, 5, 6, 1, 1, 8, 1, 0, 0, 0, 0);
        checkOutput("alu_raw_valid", 32'(ex_valid), FWD ? 1 : 0);
        checkOutput("alu_raw_a1", 32'(A1_sel), FWD ? 1 : 0);
        if (!FWD) applyStimulus(1, 5, 6, 1, 1, 8, 1, 0, 0, 0, 0);
        checkOutput("alu_raw_rd", 32'(ex_rd), 8);

        // Flush beats stall: branch in EX kills ID, counter unchanged
        applyStimulus(1, 1, 2, 0, 0, 7, 1, 1, 0, 0, 0);
        cntBefore = mCnt;
        applyStimulus(1, 3, 7, 0, 1, 9, 1, 0, 0, 0, 1);
        checkOutput("flush_ex_valid", 32'(ex_valid), 0);
        checkOutput("flush_mem_valid", 32'(mem_valid), 1);
        checkOutput("flush_cnt", 32'(stall_cnt), cntBefore);

        // Randomized traffic, long enough to saturate the counter
        for (int i = 0; i < 300; i++) randomCycle();

        // Asynchronous reset in the middle of a cycle with traffic running
        for (int i = 0; i < 10; i++) randomCycle();
        id_valid = 1; id_rd = AW'(3); id_we = 1; ex_br_taken = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_ex_valid", 32'(ex_valid), 0);
        checkOutput("rst_ex_rd", 32'(ex_rd), 0);
        checkOutput("rst_ex_we", 32'(ex_we), 0);
        checkOutput("rst_mem_valid", 32'(mem_valid), 0);
        checkOutput("rst_mem_rd", 32'(mem_rd), 0);
        checkOutput("rst_sels", {28'b0, A1_sel, B1_sel, A2_sel, B2_sel}, 0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("rst_id_stall", 32'(id_stall), 0);
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) randomCycle();
        compareState();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
